dm_bytelane: RTL and testbench



---
 rtl/dm_pkg.sv | 52 +++++
 rtl/dm_ram_be.sv | 24 ++
 rtl/dm_bytelane.sv | 114 +++++++++++
 tb/tb_dm_bytelane.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-lane data memory.
package dm_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   // Byte-write enables for a store of the given size at the given lane.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: byte_en = 4'b0001 << lane;
         SZ_HALF: byte_en = 4'b0011 << lane;
         SZ_WORD: byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

   // Replicate store data into every lane so the enables alone pick the target bytes.
   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: store_data = {4{wdata[7:0]}};
         SZ_HALF: store_data = {2{wdata[15:0]}};
         default: store_data = wdata;
      endcase
   endfunction

   // Alignment / legality check on size and low address bits.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = lane[0];
         SZ_WORD: misaligned = (lane != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

   // Extract the addressed lane from a read word and sign/zero-extend it.
   function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                            input logic [1:0] lane, input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         SZ_BYTE: load_ext = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: load_ext = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         SZ_WORD: load_ext = word;
         default: load_ext = '0;
      endcase
   endfunction

endpackage

// File: rtl/dm_ram_be.sv
// Single-port RAM, 32-bit words, per-byte write enable, registered read.
module dm_ram_be #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [3:0]    wr_be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-masked write and synchronous read; callers never assert both in one cycle.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (wr_be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/dm_bytelane.sv
// Byte-enabled data memory with valid/ready request and fixed-latency response.
module dm_bytelane
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned RD_LAT      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(64'(DEPTH_WORDS) << 2);

   logic          accept;
   logic [1:0]    lane;
   logic          req_err;
   logic [3:0]    wr_be;
   logic          rd_en;
   logic [31:0]   ram_rdata;

   assign req_ready = !rst;
   assign accept    = req_valid && req_ready;
   assign lane      = req_addr[1:0];
   assign req_err   = misaligned(req_size, lane) || ({1'b0, req_addr} >= LIMIT);
   assign wr_be     = (accept && req_we && !req_err) ? byte_en(req_size, lane) : 4'b0000;
   assign rd_en     = accept && !req_we && !req_err;

   dm_ram_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .rd_en (rd_en),
      .wr_be (wr_be),
      .addr  (req_addr[AW+1:2]),
      .wdata (store_data(req_size, req_wdata)),
      .rdata (ram_rdata)
   );

   logic        s1_valid;
   logic        s1_we;
   logic [1:0]  s1_size;
   logic        s1_uns;
   logic [1:0]  s1_lane;
   logic        s1_err;
   logic [31:0] s1_data;

   // Stage-1 valid tracks accepted requests; cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) s1_valid <= 1'b0;
      else     s1_valid <= accept;
   end

   // Stage-1 request attributes, aligned with the RAM read data.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_we   <= req_we;
         s1_size <= req_size;
         s1_uns  <= req_unsigned;
         s1_lane <= lane;
         s1_err  <= req_err;
      end
   end

   assign s1_data = (s1_we || s1_err) ? '0 : load_ext(s1_size, s1_uns, s1_lane, ram_rdata);

   logic        out_valid;
   logic        out_err;
   logic [31:0] out_data;

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic        s2_valid;
         logic        s2_err;
         logic [31:0] s2_data;

         // Output register stage after extension.
         always_ff @(posedge clk) begin
            if (rst) s2_valid <= 1'b0;
            else     s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_err  <= s1_err;
               s2_data <= s1_data;
            end
         end

         assign out_valid = s2_valid;
         assign out_err   = s2_err;
         assign out_data  = s2_data;
      end else begin : g_lat1
         assign out_valid = s1_valid;
         assign out_err   = s1_err;
         assign out_data  = s1_data;
      end
   endgenerate

   // Reset also masks the current-cycle response so nothing in flight escapes.
   assign rsp_valid = out_valid && !rst;
   assign rsp_err   = rsp_valid && out_err;
   assign rsp_rdata = rsp_valid ? out_data : '0;

endmodule

// File: tb/tb_dm_bytelane.sv
// Scoreboard bench: one stimulus stream drives RD_LAT=1 and RD_LAT=2 instances.
module tb_dm_bytelane;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;

   logic        req_ready1, rsp_valid1, rsp_err1;
   logic [31:0] rsp_rdata1;
   logic        req_ready2, rsp_valid2, rsp_err2;
   logic [31:0] rsp_rdata2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic end_check = 1'b0;
   logic end_done = 1'b0;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   dm_bytelane #(.DEPTH_WORDS(1024), .ADDR_W(32), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
   );

   dm_bytelane #(.DEPTH_WORDS(1024), .ADDR_W(32), .RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_rsp(input int id, input logic [31:0] rd, input logic er);
      exp_t e;
      int   n;
      n = (id == 1) ? q1.size() : q2.size();
      if (n == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_rsp_dut%0d got rdata=%h err=%b required no response", id, rd, er);
      end else begin
         if (id == 1) e = q1.pop_front();
         else         e = q2.pop_front();
         chk($sformatf("rdata_dut%0d", id), rd, e.rd);
         chk($sformatf("err_dut%0d", id), {31'b0, er}, {31'b0, e.err});
         chk($sformatf("latency_cycle_dut%0d", id), cyc, e.cyc);
      end
   endtask

   // Monitor: reset-state checks while rst is high, response scoreboard otherwise.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_ready1", {31'b0, req_ready1}, 32'd0);
         chk("rst_valid1", {31'b0, rsp_valid1}, 32'd0);
         chk("rst_rdata1", rsp_rdata1, 32'd0);
         chk("rst_err1",   {31'b0, rsp_err1},   32'd0);
         chk("rst_ready2", {31'b0, req_ready2}, 32'd0);
         chk("rst_valid2", {31'b0, rsp_valid2}, 32'd0);
         chk("rst_rdata2", rsp_rdata2, 32'd0);
         chk("rst_err2",   {31'b0, rsp_err2},   32'd0);
      end else begin
         chk("ready1", {31'b0, req_ready1}, 32'd1);
         chk("ready2", {31'b0, req_ready2}, 32'd1);
         if (rsp_valid1) check_rsp(1, rsp_rdata1, rsp_err1);
         if (rsp_valid2) check_rsp(2, rsp_rdata2, rsp_err2);
      end
      if (end_check && !end_done) begin
         checks++;
         if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL missing_rsp pending dut1=%0d dut2=%0d required 0", q1.size(), q2.size());
         end
         end_done = 1'b1;
      end
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] erd, input logic eerr);
      exp_t e;
      @(negedge clk);
      #1;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      e.rd  = erd;
      e.err = eerr;
      e.cyc = cyc + 1;
      q1.push_back(e);
      e.cyc = cyc + 2;
      q2.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         req_valid = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // word store / load
      issue(1, 2'b10, 0, 32'h10, 32'h8877_6655, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8877_6655, 0);
      // byte store over the word, signed/unsigned byte loads
      issue(1, 2'b00, 0, 32'h13, 32'h0000_00AB, 32'h0, 0);
      issue(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFF_FFAB, 0);
      issue(0, 2'b00, 1, 32'h13, 32'h0, 32'h0000_00AB, 0);
      issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hAB77_6655, 0);
      // half stores / loads
      issue(1, 2'b01, 0, 32'h12, 32'h0000_1234, 32'h0, 0);
      issue(0, 2'b01, 0, 32'h12, 32'h0, 32'h0000_1234, 0);
      issue(0, 2'b01, 0, 32'h10, 32'h0, 32'h0000_6655, 0);
      issue(1, 2'b01, 0, 32'h10, 32'h0000_8000, 32'h0, 0);
      issue(0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFF_8000, 0);
      issue(0, 2'b01, 1, 32'h10, 32'h0, 32'h0000_8000, 0);
      issue(0, 2'b10, 1, 32'h10, 32'h0, 32'h1234_8000, 0);
      // error cases, memory must stay unchanged
      issue(1, 2'b10, 0, 32'h0, 32'hCAFE_F00D, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1);
      issue(1, 2'b01, 0, 32'h13, 32'h0000_FFFF, 32'h0, 1);
      issue(1, 2'b10, 0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1);
      issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
      issue(1, 2'b11, 0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1);
      issue(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
      issue(1, 2'b10, 0, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1);
      issue(1, 2'b00, 0, 32'h8000_0000, 32'h0000_00EE, 32'h0, 1);
      issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h1234_8000, 0);
      issue(0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0);
      // last valid word
      issue(1, 2'b10, 0, 32'hFFC, 32'h5A5A_A5A5, 32'h0, 0);
      issue(0, 2'b00, 0, 32'hFFF, 32'h0, 32'h0000_005A, 0);
      issue(0, 2'b10, 0, 32'hFFC, 32'h0, 32'h5A5A_A5A5, 0);
      // back-to-back store then load
      issue(1, 2'b10, 0, 32'h20, 32'h0000_0001, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h0000_0001, 0);
      issue(1, 2'b00, 0, 32'h21, 32'h0000_007F, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h0000_7F01, 0);
      issue(0, 2'b00, 0, 32'h21, 32'h0, 32'h0000_007F, 0);
      issue(0, 2'b01, 0, 32'h22, 32'h0, 32'h0000_0000, 0);
      // store that must survive reset
      issue(1, 2'b10, 0, 32'h30, 32'h1122_3344, 32'h0, 0);
      idle(3);

      // load accepted, then reset the following cycle: its response is dropped
      @(negedge clk);
      #1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h30;
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      idle(3);

      issue(0, 2'b10, 0, 32'h30, 32'h0, 32'h1122_3344, 0);
      issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h0000_7F01, 0);
      idle(1);

      for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
      #1 end_check = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
